// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with two-flop synchronizer,
// press/release debounce and a two-entry history of accepted hex keys.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 24000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CMAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                          SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [3:0]    sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    digit_new_q, digit_new_d;
    logic [3:0]    digit_old_q, digit_old_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          one_low;
    logic [1:0]    low_idx;
    logic          row_up;

    function automatic logic [3:0] keymap(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] k;
        case ({r, c})
            4'd0:    k = 4'h1;
            4'd1:    k = 4'h2;
            4'd2:    k = 4'h3;
            4'd3:    k = 4'hA;
            4'd4:    k = 4'h4;
            4'd5:    k = 4'h5;
            4'd6:    k = 4'h6;
            4'd7:    k = 4'hB;
            4'd8:    k = 4'h7;
            4'd9:    k = 4'h8;
            4'd10:   k = 4'h9;
            4'd11:   k = 4'hC;
            4'd12:   k = 4'hE;
            4'd13:   k = 4'h0;
            4'd14:   k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Exactly one synchronized row low; multi-row presses count as none.
    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (sync2_q)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign row_up = sync2_q[row_idx_q];

    // Scan / debounce / hold / release sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        unique case (state_q)
            S_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        row_idx_d = low_idx;
                        state_d   = S_DEB;
                    end else begin
                        col_d     = {col_q[2:0], col_q[3]};
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DEB: begin
                if (row_up) begin
                    state_d   = S_SCAN;
                    cnt_d     = '0;
                    col_d     = {col_q[2:0], col_q[3]};
                    col_idx_d = col_idx_q + 2'd1;
                end else if (cnt_q == DEB_LAST) begin
                    digit_old_d = digit_new_q;
                    digit_new_d = keymap(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = S_HELD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HELD: begin
                if (row_up) begin
                    cnt_d   = '0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!row_up) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = S_SCAN;
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    // State and synchronizer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            state_q     <= S_SCAN;
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= row;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving keypad_scanner, with a
// scoreboard queue of expected {digit_new, digit_old} per key_valid.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  digit_new;
    logic [3:0]  digit_old;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .digit_new(digit_new),
        .digit_old(digit_old),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] col_of(input int k);
        logic [3:0] v;
        case (k % 4)
            0:       v = 4'b1110;
            1:       v = 4'b1101;
            2:       v = 4'b1011;
            default: v = 4'b0111;
        endcase
        return v;
    endfunction

    // Monitor: every key_valid pulse pops one expected digit pair.
    initial begin
        logic prev_kv;
        logic [7:0] e;
        prev_kv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_kv = 1'b0;
            end else begin
                if (key_valid) begin
                    chk("kv_single", {7'd0, prev_kv}, 8'd0);
                    chk("kv_expected", {7'd0, exp_q.size() != 0}, 8'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("digits", {digit_new, digit_old}, e);
                    end
                end
                prev_kv = key_valid;
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, {7'd0, exp_q.size() == 0}, 8'd1);
    endtask

    task automatic wait_held(input logic v, input string name);
        int n;
        n = 0;
        while (key_held !== v && n < 60) begin
            tick();
            n++;
        end
        chk(name, {7'd0, key_held}, {7'd0, v});
    endtask

    task automatic wait_freeze(input logic [3:0] target, input string name);
        int run;
        int n;
        run = 0;
        n = 0;
        while (run < 5 && n < 200) begin
            tick();
            n++;
            if (col == target) run++;
            else run = 0;
        end
        chk(name, {7'd0, run == 5}, 8'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"}, {4'd0, col}, 8'h0E);
        chk({tag, "_dn"}, {4'd0, digit_new}, 8'h00);
        chk({tag, "_do"}, {4'd0, digit_old}, 8'h00);
        chk({tag, "_kv"}, {7'd0, key_valid}, 8'h00);
        chk({tag, "_kh"}, {7'd0, key_held}, 8'h00);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        pressed = 16'h0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("rotate", {4'd0, col}, {4'd0, col_of(i / 4)});
        end

        // Key 5: row 1, column 1.
        pressed[5] = 1'b1;
        exp_q.push_back(8'h50);
        wait_drain("key5");
        chk("key5_held", {7'd0, key_held}, 8'd1);
        chk("key5_col", {4'd0, col}, 8'h0D);
        tick();
        chk("key5_kv_low", {7'd0, key_valid}, 8'd0);

        // Release, then key 0: row 3, column 1.
        pressed[5] = 1'b0;
        wait_held(1'b0, "rel5");
        pressed[13] = 1'b1;
        exp_q.push_back(8'h05);
        wait_drain("key0");
        chk("key0_held", {7'd0, key_held}, 8'd1);
        pressed[13] = 1'b0;
        wait_held(1'b0, "rel0");

        // Key 7 too short: debounce aborts, next column scanned.
        pressed[8] = 1'b1;
        wait_freeze(4'b1110, "frz7");
        repeat (3) tick();
        pressed[8] = 1'b0;
        n = 0;
        while (col == 4'b1110 && n < 12) begin
            tick();
            n++;
        end
        chk("abort_col", {4'd0, col}, 8'h0D);
        chk("abort_digits", {digit_new, digit_old}, 8'h05);
        chk("abort_held", {7'd0, key_held}, 8'd0);

        // Key 5 held with release bounce and a second row pressed.
        pressed[5] = 1'b1;
        exp_q.push_back(8'h50);
        wait_drain("key5b");
        chk("key5b_held", {7'd0, key_held}, 8'd1);
        pressed[5] = 1'b0;
        repeat (3) tick();
        pressed[5] = 1'b1;
        pressed[9] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("bounce_held", {7'd0, key_held}, 8'd1);
        end
        pressed = 16'h0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) chk("rel_hold", {7'd0, key_held}, 8'd1);
            if (i == 11) chk("rel_done", {7'd0, key_held}, 8'd0);
        end
        chk("bounce_digits", {digit_new, digit_old}, 8'h50);

        // Key 9 interrupted by reset at debounce count 5.
        pressed[10] = 1'b1;
        wait_freeze(4'b1011, "frz9");
        repeat (5) tick();
        reset   = 1'b1;
        pressed = 16'h0;
        tick();
        tick();
        chk_reset_vals("rst9");
        reset = 1'b0;
        repeat (40) tick();
        chk("post9_digits", {digit_new, digit_old}, 8'h00);
        chk("post9_held", {7'd0, key_held}, 8'd0);

        chk("queue_empty", {7'd0, exp_q.size() == 0}, 8'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
